// File: rtl/world_map_arbiter.sv
// world_map_arbiter
//   Shares the single-read-port world map ROM (128x128 x 2-bit) between the
//   video pixel fetch, the BOT Picoblaze map logic and the game collision
//   logic. One address is accepted per cycle, the ROM read is pipelined, and
//   each result is routed back to the requester that issued it.
//
//   Priority, highest first: a starved bot/game request (wait == MAX_WAIT,
//   round-robin between the two if both are starved), then video, then
//   bot/game by round-robin pointer.
//
//   Optional feature macro: MAP_XWRAP_EN
//     When defined, the x coordinate used for rom_addr is folded for the
//     sidescroller: x == 8'h7D reads column 1 and x == 8'h00 reads column
//     8'h7C. When undefined, x[6:0] is used unchanged.
//
//   Handshake: a requester raises req with x/y and holds all three stable
//   until gnt is seen high in the same cycle; gnt is combinational from req
//   and arbiter state, so the address is taken in the gnt cycle. Dropping req
//   before gnt withdraws the request with no side effects. The result comes
//   back as a one-cycle rvalid pulse 1+ROM_LAT cycles after gnt; rdata is
//   valid with that pulse and holds until the owner's next rvalid.

module world_map_arbiter #(
    parameter int ROM_LAT  = 1,   // ROM latency from rom_en to rom_data (1..4)
    parameter int MAX_WAIT = 16   // bot/game wait before overriding video (2..255)
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        vid_req,
    input  logic [7:0]  vid_x,
    input  logic [7:0]  vid_y,
    output logic        vid_gnt,
    output logic        vid_rvalid,
    output logic [1:0]  vid_rdata,

    input  logic        bot_req,
    input  logic [7:0]  bot_x,
    input  logic [7:0]  bot_y,
    output logic        bot_gnt,
    output logic        bot_rvalid,
    output logic [1:0]  bot_rdata,

    input  logic        gm_req,
    input  logic [7:0]  gm_x,
    input  logic [7:0]  gm_y,
    output logic        gm_gnt,
    output logic        gm_rvalid,
    output logic [1:0]  gm_rdata,

    output logic        rom_en,
    output logic [13:0] rom_addr,
    input  logic [1:0]  rom_data
);

    // Owner tags carried alongside each ROM read
    localparam logic [1:0] TAG_NONE = 2'd0;
    localparam logic [1:0] TAG_VID  = 2'd1;
    localparam logic [1:0] TAG_BOT  = 2'd2;
    localparam logic [1:0] TAG_GM   = 2'd3;

    localparam logic [7:0] WAIT_MAX = 8'(MAX_WAIT);

    // Column selection for the ROM address, with optional sidescroller fold
    function automatic logic [6:0] fold_x(input logic [7:0] x);
`ifdef MAP_XWRAP_EN
        if (x == 8'h7D)
            return 7'h01;
        else if (x == 8'h00)
            return 7'h7C;
        else
            return x[6:0];
`else
        return x[6:0];
`endif
    endfunction

    // ------------------------------------------------------------------
    // Arbiter state
    // ------------------------------------------------------------------
    logic [7:0] bot_wait;
    logic [7:0] gm_wait;
    logic       rr_gm;        // 0: bot next in round-robin, 1: game next

    logic       bot_starved;
    logic       gm_starved;
    logic       sel_vid;
    logic       sel_bot;
    logic       sel_gm;
    logic       any_gnt;
    logic [1:0] gnt_tag;
    logic [7:0] gnt_x;
    logic [7:0] gnt_y;

    // Bit 7 of y (and of x when folding is off) never reaches the ROM
    logic       unused_coord_bits;
    assign unused_coord_bits = ^{vid_x[7], vid_y[7], bot_x[7], bot_y[7], gm_x[7], gm_y[7]};

    assign bot_starved = bot_req && (bot_wait == WAIT_MAX);
    assign gm_starved  = gm_req  && (gm_wait  == WAIT_MAX);

    // Priority selection: starvation override, then video, then round-robin
    always_comb begin
        sel_vid = 1'b0;
        sel_bot = 1'b0;
        sel_gm  = 1'b0;
        if (bot_starved && gm_starved) begin
            if (rr_gm)
                sel_gm = 1'b1;
            else
                sel_bot = 1'b1;
        end else if (bot_starved) begin
            sel_bot = 1'b1;
        end else if (gm_starved) begin
            sel_gm = 1'b1;
        end else if (vid_req) begin
            sel_vid = 1'b1;
        end else if (bot_req && gm_req) begin
            if (rr_gm)
                sel_gm = 1'b1;
            else
                sel_bot = 1'b1;
        end else if (bot_req) begin
            sel_bot = 1'b1;
        end else if (gm_req) begin
            sel_gm = 1'b1;
        end
    end

    // Grants are suppressed while reset is held
    always_comb begin
        vid_gnt = sel_vid && !reset;
        bot_gnt = sel_bot && !reset;
        gm_gnt  = sel_gm  && !reset;
        any_gnt = vid_gnt || bot_gnt || gm_gnt;
    end

    // Address and owner tag of the granted request
    always_comb begin
        gnt_tag = TAG_NONE;
        gnt_x   = 8'h00;
        gnt_y   = 8'h00;
        if (vid_gnt) begin
            gnt_tag = TAG_VID;
            gnt_x   = vid_x;
            gnt_y   = vid_y;
        end else if (bot_gnt) begin
            gnt_tag = TAG_BOT;
            gnt_x   = bot_x;
            gnt_y   = bot_y;
        end else if (gm_gnt) begin
            gnt_tag = TAG_GM;
            gnt_x   = gm_x;
            gnt_y   = gm_y;
        end
    end

    // Wait counters: count ungranted request cycles, saturating at MAX_WAIT
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bot_wait <= 8'd0;
            gm_wait  <= 8'd0;
        end else begin
            if (!bot_req || bot_gnt)
                bot_wait <= 8'd0;
            else if (bot_wait != WAIT_MAX)
                bot_wait <= bot_wait + 8'd1;

            if (!gm_req || gm_gnt)
                gm_wait <= 8'd0;
            else if (gm_wait != WAIT_MAX)
                gm_wait <= gm_wait + 8'd1;
        end
    end

    // Round-robin pointer flips on bot/game grants, ignores video grants
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            rr_gm <= 1'b0;
        else if (bot_gnt)
            rr_gm <= 1'b1;
        else if (gm_gnt)
            rr_gm <= 1'b0;
    end

    // ------------------------------------------------------------------
    // Issue stage: registered ROM enable and address
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rom_en   <= 1'b0;
            rom_addr <= 14'd0;
        end else begin
            rom_en <= any_gnt;
            if (any_gnt)
                rom_addr <= {gnt_y[6:0], fold_x(gnt_x)};
        end
    end

    // ------------------------------------------------------------------
    // Tag pipeline: stage 0 lines up with rom_en, the last stage lines up
    // with the cycle before rom_data becomes valid.
    // ------------------------------------------------------------------
    logic [1:0] tag_pipe [ROM_LAT];
    logic [1:0] ret_tag;

    // Shift owner tags alongside the ROM read
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ROM_LAT; i++)
                tag_pipe[i] <= TAG_NONE;
        end else begin
            tag_pipe[0] <= gnt_tag;
            for (int i = 1; i < ROM_LAT; i++)
                tag_pipe[i] <= tag_pipe[i-1];
        end
    end

    assign ret_tag = tag_pipe[ROM_LAT-1];

    // ------------------------------------------------------------------
    // Return stage
    // ------------------------------------------------------------------
    logic [1:0] vid_hold;
    logic [1:0] bot_hold;
    logic [1:0] gm_hold;

    // One-cycle rvalid pulse to the owner, aligned with valid rom_data
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vid_rvalid <= 1'b0;
            bot_rvalid <= 1'b0;
            gm_rvalid  <= 1'b0;
        end else begin
            vid_rvalid <= (ret_tag == TAG_VID);
            bot_rvalid <= (ret_tag == TAG_BOT);
            gm_rvalid  <= (ret_tag == TAG_GM);
        end
    end

    // Capture the returned value so rdata holds until the next return
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vid_hold <= 2'd0;
            bot_hold <= 2'd0;
            gm_hold  <= 2'd0;
        end else begin
            if (vid_rvalid)
                vid_hold <= rom_data;
            if (bot_rvalid)
                bot_hold <= rom_data;
            if (gm_rvalid)
                gm_hold <= rom_data;
        end
    end

    // rdata shows rom_data during the rvalid pulse, the captured copy after
    always_comb begin
        vid_rdata = vid_rvalid ? rom_data : vid_hold;
        bot_rdata = bot_rvalid ? rom_data : bot_hold;
        gm_rdata  = gm_rvalid  ? rom_data : gm_hold;
    end

endmodule

// File: tb/tb_world_map_arbiter.sv
// tb_world_map_arbiter
//   Directed bench for world_map_arbiter. Two instances: the default build
//   (ROM_LAT=1) and a ROM_LAT=3 build for the back-to-back latency scenario.
//   Each instance gets its own ROM model with the matching read latency.
//   MAP_XWRAP_EN selects the expected folded addresses.

module tb_world_map_arbiter;

    logic clk;
    logic reset;

    // Default instance signals
    logic        vid_req, bot_req, gm_req;
    logic [7:0]  vid_x, vid_y, bot_x, bot_y, gm_x, gm_y;
    logic        vid_gnt, bot_gnt, gm_gnt;
    logic        vid_rvalid, bot_rvalid, gm_rvalid;
    logic [1:0]  vid_rdata, bot_rdata, gm_rdata;
    logic        rom_en;
    logic [13:0] rom_addr;
    logic [1:0]  rom_data;

    // ROM_LAT=3 instance signals
    logic        t3_vid_req, t3_bot_req, t3_gm_req;
    logic [7:0]  t3_vid_x, t3_vid_y, t3_bot_x, t3_bot_y, t3_gm_x, t3_gm_y;
    logic        t3_vid_gnt, t3_bot_gnt, t3_gm_gnt;
    logic        t3_vid_rvalid, t3_bot_rvalid, t3_gm_rvalid;
    logic [1:0]  t3_vid_rdata, t3_bot_rdata, t3_gm_rdata;
    logic        t3_rom_en;
    logic [13:0] t3_rom_addr;
    logic [1:0]  t3_rom_data;

    int vectors;
    int miscompares;

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUTs ----------------
    world_map_arbiter #(.ROM_LAT(1), .MAX_WAIT(16)) dut (
        .clk(clk), .reset(reset),
        .vid_req(vid_req), .vid_x(vid_x), .vid_y(vid_y),
        .vid_gnt(vid_gnt), .vid_rvalid(vid_rvalid), .vid_rdata(vid_rdata),
        .bot_req(bot_req), .bot_x(bot_x), .bot_y(bot_y),
        .bot_gnt(bot_gnt), .bot_rvalid(bot_rvalid), .bot_rdata(bot_rdata),
        .gm_req(gm_req), .gm_x(gm_x), .gm_y(gm_y),
        .gm_gnt(gm_gnt), .gm_rvalid(gm_rvalid), .gm_rdata(gm_rdata),
        .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data)
    );

    world_map_arbiter #(.ROM_LAT(3), .MAX_WAIT(16)) dut3 (
        .clk(clk), .reset(reset),
        .vid_req(t3_vid_req), .vid_x(t3_vid_x), .vid_y(t3_vid_y),
        .vid_gnt(t3_vid_gnt), .vid_rvalid(t3_vid_rvalid), .vid_rdata(t3_vid_rdata),
        .bot_req(t3_bot_req), .bot_x(t3_bot_x), .bot_y(t3_bot_y),
        .bot_gnt(t3_bot_gnt), .bot_rvalid(t3_bot_rvalid), .bot_rdata(t3_bot_rdata),
        .gm_req(t3_gm_req), .gm_x(t3_gm_x), .gm_y(t3_gm_y),
        .gm_gnt(t3_gm_gnt), .gm_rvalid(t3_gm_rvalid), .gm_rdata(t3_gm_rdata),
        .rom_en(t3_rom_en), .rom_addr(t3_rom_addr), .rom_data(t3_rom_data)
    );

    // ---------------- ROM models ----------------
    // Map contents: a fixed scramble of address bits
    function automatic logic [1:0] rom_fn(input logic [13:0] a);
        return a[1:0] ^ a[8:7] ^ {a[13], a[2]};
    endfunction

    // Latency 1: data for the address presented in cycle e appears in e+1
    logic [13:0] rom1_q;
    always @(posedge clk) rom1_q <= rom_addr;
    assign rom_data = rom_fn(rom1_q);

    // Latency 3: data for the address presented in cycle e appears in e+3
    logic [13:0] rom3_q [3];
    always @(posedge clk) begin
        rom3_q[0] <= t3_rom_addr;
        rom3_q[1] <= rom3_q[0];
        rom3_q[2] <= rom3_q[1];
    end
    assign t3_rom_data = rom_fn(rom3_q[2]);

    // ---------------- driver helpers ----------------
    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset;
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        reset = 1'b1;
        vid_req = 1'b1; bot_req = 1'b1; gm_req = 1'b1;
        t3_vid_req = 1'b1; t3_bot_req = 1'b1; t3_gm_req = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({vid_gnt, bot_gnt, gm_gnt} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_gnt: got %b expected 000", {vid_gnt, bot_gnt, gm_gnt});
        end
        vectors++;
        if ({t3_vid_gnt, t3_bot_gnt, t3_gm_gnt} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_gnt_lat3: got %b expected 000", {t3_vid_gnt, t3_bot_gnt, t3_gm_gnt});
        end
        vectors++;
        if ({rom_en, rom_addr} !== 15'd0) begin
            miscompares++;
            $display("FAIL reset_rom: got en=%b addr=%h expected en=0 addr=0000", rom_en, rom_addr);
        end
        vectors++;
        if ({vid_rvalid, bot_rvalid, gm_rvalid, vid_rdata, bot_rdata, gm_rdata} !== 9'd0) begin
            miscompares++;
            $display("FAIL reset_ret: got rv=%b rd=%h/%h/%h expected all 0",
                     {vid_rvalid, bot_rvalid, gm_rvalid}, vid_rdata, bot_rdata, gm_rdata);
        end
        next_cycle();
        vid_req = 1'b0; bot_req = 1'b0; gm_req = 1'b0;
        t3_vid_req = 1'b0; t3_bot_req = 1'b0; t3_gm_req = 1'b0;
        reset = 1'b0;
        next_cycle();
    endtask

    task automatic test_single_video;
        vid_x = 8'h05; vid_y = 8'h03; vid_req = 1'b1;
        @(negedge clk);
        vectors++;
        if ({vid_gnt, bot_gnt, gm_gnt} !== 3'b100) begin
            miscompares++;
            $display("FAIL single_gnt: got %b expected 100", {vid_gnt, bot_gnt, gm_gnt});
        end
        next_cycle();
        vid_req = 1'b0;
        @(negedge clk);
        vectors++;
        if ({rom_en, rom_addr, vid_rvalid} !== {1'b1, 14'h0185, 1'b0}) begin
            miscompares++;
            $display("FAIL single_issue: got en=%b addr=%h rv=%b expected en=1 addr=0185 rv=0",
                     rom_en, rom_addr, vid_rvalid);
        end
        next_cycle();
        @(negedge clk);
        vectors++;
        if ({vid_rvalid, vid_rdata, rom_en} !== {1'b1, rom_fn(14'h0185), 1'b0}) begin
            miscompares++;
            $display("FAIL single_return: got rv=%b rd=%h en=%b expected rv=1 rd=%h en=0",
                     vid_rvalid, vid_rdata, rom_en, rom_fn(14'h0185));
        end
        next_cycle();
        @(negedge clk);
        vectors++;
        if ({vid_rvalid, vid_rdata, rom_addr} !== {1'b0, rom_fn(14'h0185), 14'h0185}) begin
            miscompares++;
            $display("FAIL single_hold: got rv=%b rd=%h addr=%h expected rv=0 rd=%h addr=0185",
                     vid_rvalid, vid_rdata, rom_addr, rom_fn(14'h0185));
        end
        next_cycle();
    endtask

    task automatic test_starvation;
        logic [2:0] got;
        logic [2:0] exp_g;
        logic [2:0] exp_rv;
        vid_x = 8'h01; vid_y = 8'h02; vid_req = 1'b1;
        bot_x = 8'h12; bot_y = 8'h21; bot_req = 1'b1;
        gm_x  = 8'h33; gm_y  = 8'h44; gm_req  = 1'b1;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            got    = {vid_gnt, bot_gnt, gm_gnt};
            exp_g  = (c == 16) ? 3'b010 : (c == 17) ? 3'b001 : 3'b100;
            exp_rv = (c < 2) ? 3'b000 : (c == 18) ? 3'b010 : (c == 19) ? 3'b001 : 3'b100;
            vectors++;
            if (got !== exp_g) begin
                miscompares++;
                $display("FAIL starve_gnt c=%0d: got %b expected %b", c, got, exp_g);
            end
            vectors++;
            if ({vid_rvalid, bot_rvalid, gm_rvalid} !== exp_rv) begin
                miscompares++;
                $display("FAIL starve_rvalid c=%0d: got %b expected %b",
                         c, {vid_rvalid, bot_rvalid, gm_rvalid}, exp_rv);
            end
            if (c == 18) begin
                vectors++;
                if (bot_rdata !== rom_fn(14'h1092)) begin
                    miscompares++;
                    $display("FAIL starve_bot_rdata: got %h expected %h", bot_rdata, rom_fn(14'h1092));
                end
            end
            if (c == 19) begin
                vectors++;
                if (gm_rdata !== rom_fn(14'h2233)) begin
                    miscompares++;
                    $display("FAIL starve_gm_rdata: got %h expected %h", gm_rdata, rom_fn(14'h2233));
                end
            end
            next_cycle();
            if (got[1]) bot_req = 1'b0;
            if (got[0]) gm_req = 1'b0;
        end
        vid_req = 1'b0; bot_req = 1'b0; gm_req = 1'b0;
        repeat (3) next_cycle();
    endtask

    task automatic test_round_robin;
        logic [2:0]  exp_g;
        logic [2:0]  exp_rv;
        logic [13:0] exp_a;
        pulse_reset();
        bot_x = 8'h8A; bot_y = 8'h05; bot_req = 1'b1;   // x bit 7 ignored -> 0x28A
        gm_x  = 8'h7F; gm_y  = 8'h7F; gm_req  = 1'b1;   // -> 0x3FFF
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            exp_g = (c % 2 == 0) ? 3'b010 : 3'b001;
            vectors++;
            if ({vid_gnt, bot_gnt, gm_gnt} !== exp_g) begin
                miscompares++;
                $display("FAIL rr_gnt c=%0d: got %b expected %b", c, {vid_gnt, bot_gnt, gm_gnt}, exp_g);
            end
            if (c >= 1) begin
                exp_a = ((c - 1) % 2 == 0) ? 14'h028A : 14'h3FFF;
                vectors++;
                if ({rom_en, rom_addr} !== {1'b1, exp_a}) begin
                    miscompares++;
                    $display("FAIL rr_issue c=%0d: got en=%b addr=%h expected en=1 addr=%h",
                             c, rom_en, rom_addr, exp_a);
                end
            end
            if (c >= 2) begin
                exp_rv = (c % 2 == 0) ? 3'b010 : 3'b001;
                vectors++;
                if ({vid_rvalid, bot_rvalid, gm_rvalid} !== exp_rv) begin
                    miscompares++;
                    $display("FAIL rr_rvalid c=%0d: got %b expected %b",
                             c, {vid_rvalid, bot_rvalid, gm_rvalid}, exp_rv);
                end
                vectors++;
                if (c % 2 == 0 && bot_rdata !== rom_fn(14'h028A)) begin
                    miscompares++;
                    $display("FAIL rr_bot_rdata c=%0d: got %h expected %h", c, bot_rdata, rom_fn(14'h028A));
                end else if (c % 2 == 1 && gm_rdata !== rom_fn(14'h3FFF)) begin
                    miscompares++;
                    $display("FAIL rr_gm_rdata c=%0d: got %h expected %h", c, gm_rdata, rom_fn(14'h3FFF));
                end
            end
            next_cycle();
        end
        bot_req = 1'b0; gm_req = 1'b0;
        repeat (3) next_cycle();
    endtask

    task automatic test_reset_mid;
        bot_x = 8'h10; bot_y = 8'h01; bot_req = 1'b1;
        @(negedge clk);
        vectors++;
        if ({vid_gnt, bot_gnt, gm_gnt} !== 3'b010) begin
            miscompares++;
            $display("FAIL midrst_gnt: got %b expected 010", {vid_gnt, bot_gnt, gm_gnt});
        end
        next_cycle();
        reset = 1'b1;
        bot_req = 1'b0;
        #1;
        vectors++;
        if ({rom_en, rom_addr, bot_rdata, gm_rdata, vid_rdata} !== 21'd0) begin
            miscompares++;
            $display("FAIL midrst_immediate: got en=%b addr=%h rd=%h/%h/%h expected all 0",
                     rom_en, rom_addr, vid_rdata, bot_rdata, gm_rdata);
        end
        next_cycle();
        reset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            vectors++;
            if ({vid_rvalid, bot_rvalid, gm_rvalid, rom_en} !== 4'b0000) begin
                miscompares++;
                $display("FAIL midrst_quiet c=%0d: got rv=%b en=%b expected rv=000 en=0",
                         c, {vid_rvalid, bot_rvalid, gm_rvalid}, rom_en);
            end
            next_cycle();
        end
    endtask

    task automatic test_back_to_back;
        logic [2:0]  got;
        logic [2:0]  exp_g;
        logic [2:0]  exp_rv;
        logic        exp_en;
        pulse_reset();
        t3_vid_x = 8'h01; t3_vid_y = 8'h01; t3_vid_req = 1'b1;   // 0x0081
        t3_bot_x = 8'h02; t3_bot_y = 8'h02; t3_bot_req = 1'b1;   // 0x0102
        t3_gm_x  = 8'h03; t3_gm_y  = 8'h03; t3_gm_req  = 1'b1;   // 0x0183
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            got    = {t3_vid_gnt, t3_bot_gnt, t3_gm_gnt};
            exp_g  = (c == 0) ? 3'b100 : (c == 1) ? 3'b010 : (c == 2) ? 3'b001 : 3'b000;
            exp_en = (c >= 1 && c <= 3);
            exp_rv = (c == 4) ? 3'b100 : (c == 5) ? 3'b010 : (c == 6) ? 3'b001 : 3'b000;
            vectors++;
            if (got !== exp_g) begin
                miscompares++;
                $display("FAIL b2b_gnt c=%0d: got %b expected %b", c, got, exp_g);
            end
            vectors++;
            if (t3_rom_en !== exp_en) begin
                miscompares++;
                $display("FAIL b2b_rom_en c=%0d: got %b expected %b", c, t3_rom_en, exp_en);
            end
            vectors++;
            if ({t3_vid_rvalid, t3_bot_rvalid, t3_gm_rvalid} !== exp_rv) begin
                miscompares++;
                $display("FAIL b2b_rvalid c=%0d: got %b expected %b",
                         c, {t3_vid_rvalid, t3_bot_rvalid, t3_gm_rvalid}, exp_rv);
            end
            if (c == 6) begin
                vectors++;
                if ({t3_vid_rdata, t3_bot_rdata, t3_gm_rdata} !==
                    {rom_fn(14'h0081), rom_fn(14'h0102), rom_fn(14'h0183)}) begin
                    miscompares++;
                    $display("FAIL b2b_rdata: got %h/%h/%h expected %h/%h/%h",
                             t3_vid_rdata, t3_bot_rdata, t3_gm_rdata,
                             rom_fn(14'h0081), rom_fn(14'h0102), rom_fn(14'h0183));
                end
            end
            next_cycle();
            if (got[2]) t3_vid_req = 1'b0;
            if (got[1]) t3_bot_req = 1'b0;
            if (got[0]) t3_gm_req = 1'b0;
        end
        t3_vid_req = 1'b0; t3_bot_req = 1'b0; t3_gm_req = 1'b0;
    endtask

    task automatic test_xwrap;
        logic [13:0] exp_7d;
        logic [13:0] exp_00;
`ifdef MAP_XWRAP_EN
        exp_7d = 14'h0001;
        exp_00 = 14'h007C;
`else
        exp_7d = 14'h007D;
        exp_00 = 14'h0000;
`endif
        gm_x = 8'h7D; gm_y = 8'h00; gm_req = 1'b1;
        @(negedge clk);
        vectors++;
        if (gm_gnt !== 1'b1) begin
            miscompares++;
            $display("FAIL xwrap_gnt: got %b expected 1", gm_gnt);
        end
        next_cycle();
        gm_x = 8'h00;
        @(negedge clk);
        vectors++;
        if (rom_addr !== exp_7d) begin
            miscompares++;
            $display("FAIL xwrap_7d: got %h expected %h", rom_addr, exp_7d);
        end
        next_cycle();
        gm_req = 1'b0;
        @(negedge clk);
        vectors++;
        if (rom_addr !== exp_00) begin
            miscompares++;
            $display("FAIL xwrap_00: got %h expected %h", rom_addr, exp_00);
        end
        repeat (3) next_cycle();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        vectors = 0;
        miscompares = 0;
        reset = 1'b1;
        vid_req = 1'b0; bot_req = 1'b0; gm_req = 1'b0;
        vid_x = 8'h00; vid_y = 8'h00; bot_x = 8'h00; bot_y = 8'h00; gm_x = 8'h00; gm_y = 8'h00;
        t3_vid_req = 1'b0; t3_bot_req = 1'b0; t3_gm_req = 1'b0;
        t3_vid_x = 8'h00; t3_vid_y = 8'h00; t3_bot_x = 8'h00; t3_bot_y = 8'h00;
        t3_gm_x = 8'h00; t3_gm_y = 8'h00;

        test_reset();
        test_single_video();
        test_starvation();
        test_round_robin();
        test_reset_mid();
        test_back_to_back();
        test_xwrap();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
